// File: rtl/err_delay_tuner_pkg.sv
// err_delay_tuner_pkg
//   Shared definitions for the delay-line calibration scheduler.
//   - state_e    : scheduler FSM state encoding (binary, 3 bits)
//   - tap_adjust : saturating one-step tap move used by the evaluation pass
package err_delay_tuner_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StCount   = 3'd1,
      StEval    = 3'd2,
      StReq     = 3'd3,
      StRelease = 3'd4
   } state_e;

   // One evaluation step for a single stage. Raising wins over lowering;
   // both directions clamp at the ends of the tap range.
   function automatic int unsigned tap_adjust(input int unsigned tap,
                                              input int unsigned tap_max,
                                              input logic        up,
                                              input logic        dn);
      if (up) begin
         return (tap >= tap_max) ? tap_max : tap + 1;
      end else if (dn) begin
         return (tap == 0) ? 0 : tap - 1;
      end
      return tap;
   endfunction

endpackage

// File: rtl/err_delay_tuner_event_ctr.sv
// err_delay_tuner_event_ctr
//   Per-stage pair of saturating event counters: one for near-miss (err0)
//   pulses and one for timing-error (err1) pulses. Both may count in the
//   same cycle.
// Ports
//   clk   in   system clock
//   rst   in   synchronous reset, active low
//   clr   in   clear both counters (wins over en)
//   en    in   count enable (observation window active)
//   err0  in   near-miss pulse
//   err1  in   timing-error pulse
//   cnt0  out  near-miss count, saturating at 2^CNTW-1
//   cnt1  out  timing-error count, saturating at 2^CNTW-1
module err_delay_tuner_event_ctr #(
   parameter int unsigned CNTW = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            en,
   input  logic            err0,
   input  logic            err1,
   output logic [CNTW-1:0] cnt0,
   output logic [CNTW-1:0] cnt1
);

   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic [CNTW-1:0] cnt0_q;
   logic [CNTW-1:0] cnt1_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (clr) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (en) begin
         if (err0 && (cnt0_q != CNT_MAX)) begin
            cnt0_q <= cnt0_q + 1'b1;
         end
         if (err1 && (cnt1_q != CNT_MAX)) begin
            cnt1_q <= cnt1_q + 1'b1;
         end
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;

endmodule

// File: rtl/err_delay_tuner.sv
// err_delay_tuner
//   Calibration scheduler for the matched-delay lines of NSTAGES
//   error-detecting asynchronous pipeline stages. Counts err1/err0 events per
//   stage over a WINDOW-cycle observation window, then walks the stages in
//   index order nudging a shadow tap up on repeated errors or down when the
//   stage was quiet. If any shadow tap moved, the new tap vector is committed
//   to the delay lines over a 4-phase req/ack handshake; tap_o only changes
//   when the ack is seen, so a delay line never sees a tap change mid-cycle.
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active low
//   cal_en   in   calibration enable (level)
//   err1     in   per-stage timing-error pulse
//   err0     in   per-stage near-miss pulse
//   cfg_ack  in   delay-line configuration acknowledge
//   cfg_req  out  configuration request (registered)
//   tap_o    out  committed taps, stage i at [i*TAPW +: TAPW]
//   busy     out  high whenever the scheduler is not idle
module err_delay_tuner #(
   parameter int unsigned NSTAGES  = 4,
   parameter int unsigned TAPW     = 3,
   parameter int unsigned TAP_INIT = 4,
   parameter int unsigned WINDOW   = 255,
   parameter int unsigned CNTW     = 6,
   parameter int unsigned UP_THR   = 2,
   parameter int unsigned DN_THR   = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cal_en,
   input  logic [NSTAGES-1:0]      err1,
   input  logic [NSTAGES-1:0]      err0,
   input  logic                    cfg_ack,
   output logic                    cfg_req,
   output logic [NSTAGES*TAPW-1:0] tap_o,
   output logic                    busy
);

   import err_delay_tuner_pkg::*;

   localparam int unsigned WINW    = $clog2(WINDOW + 1);
   localparam int unsigned IDXW    = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
   localparam int unsigned TAP_MAX = (1 << TAPW) - 1;

   localparam logic [WINW-1:0] WIN_LAST   = WINW'(WINDOW - 1);
   localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NSTAGES - 1);
   localparam logic [CNTW-1:0] UP_THR_C   = CNTW'(UP_THR);
   localparam logic [CNTW-1:0] DN_THR_C   = CNTW'(DN_THR);
   localparam logic [TAPW-1:0] TAP_INIT_C = TAPW'(TAP_INIT);

   state_e                         state_q;
   logic [WINW-1:0]                win_cnt_q;
   logic [IDXW-1:0]                idx_q;
   logic [NSTAGES-1:0][TAPW-1:0]   shadow_q;
   logic [NSTAGES-1:0][TAPW-1:0]   tap_q;
   logic                           cfg_req_q;

   logic [NSTAGES-1:0][CNTW-1:0]   cnt0;
   logic [NSTAGES-1:0][CNTW-1:0]   cnt1;
   logic                           ctr_clr;
   logic                           ctr_en;

   logic [CNTW-1:0]                sel_cnt0;
   logic [CNTW-1:0]                sel_cnt1;
   logic                           step_up;
   logic                           step_dn;
   logic [NSTAGES-1:0][TAPW-1:0]   shadow_nxt;
   logic                           taps_differ;

   // ---------------------------------------------------------------------
   // Event counters
   // ---------------------------------------------------------------------
   // Counters only run inside the window. They are held clear everywhere a
   // fresh window may follow next cycle (idle, abort, last evaluation step,
   // handshake) so every window starts from zero.
   always_comb begin
      ctr_en  = (state_q == StCount);
      ctr_clr = 1'b0;
      unique case (state_q)
         StIdle:    ctr_clr = 1'b1;
         StCount:   ctr_clr = !cal_en;
         StEval:    ctr_clr = (idx_q == IDX_LAST);
         StReq:     ctr_clr = 1'b1;
         StRelease: ctr_clr = 1'b1;
         default:   ctr_clr = 1'b1;
      endcase
   end

   for (genvar s = 0; s < NSTAGES; s++) begin : g_ctr
      err_delay_tuner_event_ctr #(
         .CNTW(CNTW)
      ) u_ctr (
         .clk  (clk),
         .rst  (rst),
         .clr  (ctr_clr),
         .en   (ctr_en),
         .err0 (err0[s]),
         .err1 (err1[s]),
         .cnt0 (cnt0[s]),
         .cnt1 (cnt1[s])
      );
   end

   // ---------------------------------------------------------------------
   // Evaluation of the stage selected by idx_q
   // ---------------------------------------------------------------------
   // taps_differ looks at the shadow vector including this cycle's update,
   // so the decision on the last stage sees the complete new vector.
   always_comb begin
      sel_cnt0   = cnt0[idx_q];
      sel_cnt1   = cnt1[idx_q];
      step_up    = (sel_cnt1 >= UP_THR_C);
      step_dn    = (sel_cnt1 == '0) && (sel_cnt0 <= DN_THR_C);
      shadow_nxt = shadow_q;
      shadow_nxt[idx_q] = TAPW'(tap_adjust(32'(shadow_q[idx_q]), TAP_MAX, step_up, step_dn));
      taps_differ = (shadow_nxt != tap_q);
   end

   // ---------------------------------------------------------------------
   // Scheduler FSM, window counter, stage index, taps and handshake
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         win_cnt_q <= '0;
         idx_q     <= '0;
         shadow_q  <= {NSTAGES{TAP_INIT_C}};
         tap_q     <= {NSTAGES{TAP_INIT_C}};
         cfg_req_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cal_en) begin
                  state_q   <= StCount;
                  win_cnt_q <= '0;
               end
            end

            StCount: begin
               if (!cal_en) begin
                  state_q <= StIdle;
               end else if (win_cnt_q == WIN_LAST) begin
                  state_q <= StEval;
                  idx_q   <= '0;
               end else begin
                  win_cnt_q <= win_cnt_q + 1'b1;
               end
            end

            // cal_en is deliberately not looked at until the pass is done.
            StEval: begin
               shadow_q <= shadow_nxt;
               if (idx_q == IDX_LAST) begin
                  if (taps_differ) begin
                     state_q   <= StReq;
                     cfg_req_q <= 1'b1;
                  end else if (cal_en) begin
                     state_q   <= StCount;
                     win_cnt_q <= '0;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end

            // An ack already high on entry commits on the first REQ cycle.
            StReq: begin
               if (cfg_ack) begin
                  tap_q     <= shadow_q;
                  cfg_req_q <= 1'b0;
                  state_q   <= StRelease;
               end
            end

            // No new window until the delay lines drop their ack.
            StRelease: begin
               if (!cfg_ack) begin
                  if (cal_en) begin
                     state_q   <= StCount;
                     win_cnt_q <= '0;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end

            default: begin
               state_q   <= StIdle;
               cfg_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_req = cfg_req_q;
   assign tap_o   = tap_q;
   assign busy    = (state_q != StIdle);

endmodule
